insn_fetch: RTL

INSN_FETCH -- requirements
Module: insn_fetch

---
 rtl/insn_fetch_if.sv | 40 ++++
 rtl/insn_fetch.sv | 136 +++++++++++++
 2 files changed

// File: rtl/insn_fetch_if.sv
// Fetch-to-ROM and fetch-to-executor signal bundle for insn_fetch.
// master = fetch unit, slave = ROM/executor side.
interface insn_fetch_if;
    logic [15:0] address_rom;
    logic [15:0] q_rom;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        insn_valid;
    logic        insn_ready;
    logic [15:0] insn_opcode;
    logic [15:0] insn_operand;
    logic [15:0] insn_pc;
    logic        insn_illegal;

    modport master (
        output address_rom,
        input  q_rom,
        input  redirect_valid,
        input  redirect_pc,
        output insn_valid,
        input  insn_ready,
        output insn_opcode,
        output insn_operand,
        output insn_pc,
        output insn_illegal
    );

    modport slave (
        input  address_rom,
        output q_rom,
        output redirect_valid,
        output redirect_pc,
        input  insn_valid,
        output insn_ready,
        input  insn_opcode,
        input  insn_operand,
        input  insn_pc,
        input  insn_illegal
    );
endinterface

// File: rtl/insn_fetch.sv
// Instruction fetch: streams words from a synchronous ROM, assembles one/two-word
// instructions into a small queue. Define INSN_FETCH_ILLEGAL_EN to flag opcodes > 0x17 and halt.
module insn_fetch #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic         clock,
    input  logic         reset,
    insn_fetch_if.master bus
);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    typedef enum logic {ST_OPCODE, ST_OPERAND} state_t;

    typedef struct packed {
        logic [15:0] pc;
        logic [15:0] opcode;
        logic [15:0] operand;
        logic        illegal;
    } entry_t;

    state_t        state;
    entry_t        q [DEPTH];
    logic [CW-1:0] count;
    logic          valid;
    logic          inflight;
    logic          halted;
    logic [15:0]   addr;
    logic [15:0]   inflight_pc;
    logic [15:0]   held_pc;
    logic [15:0]   held_op;

    logic          two_word_c;
    logic          illegal_word_c;
    logic          push_c;
    logic          pop_c;
    logic          halt_c;
    logic          issue_c;
    logic [CW-1:0] wr_idx_c;
    logic [CW-1:0] count_nxt_c;
    entry_t        entry_c;
    int unsigned   occupancy_c;

`ifdef INSN_FETCH_ILLEGAL_EN
    assign illegal_word_c   = (bus.q_rom > 16'h0017);
    assign bus.insn_illegal = q[0].illegal;
`else
    assign illegal_word_c   = 1'b0;
    assign bus.insn_illegal = 1'b0;
`endif

    // Decode of the returning ROM word and fetch throttling.
    always_comb begin
        two_word_c  = (bus.q_rom == 16'h0001) ||
                      (bus.q_rom >= 16'h0006 && bus.q_rom <= 16'h0009);
        push_c      = inflight && (state == ST_OPERAND || !two_word_c);
        halt_c      = inflight && (state == ST_OPCODE) && illegal_word_c;
        pop_c       = valid && bus.insn_ready;
        // A held opcode is counted conservatively so the queue can never overflow.
        occupancy_c = 32'(count) + 32'(inflight) + 32'(state == ST_OPERAND);
        issue_c     = (occupancy_c < DEPTH) && !halted && !halt_c && !bus.redirect_valid;

        if (state == ST_OPERAND) begin
            entry_c = '{pc: held_pc, opcode: held_op, operand: bus.q_rom, illegal: 1'b0};
        end else begin
            entry_c = '{pc: inflight_pc, opcode: bus.q_rom, operand: 16'h0000,
                        illegal: illegal_word_c};
        end

        wr_idx_c    = pop_c ? count - CW'(1) : count;
        count_nxt_c = count + CW'(push_c) - CW'(pop_c);
    end

    // Fetch PC, assembler state and shift-register queue (entry 0 is the head).
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= ST_OPCODE;
            count       <= '0;
            valid       <= 1'b0;
            inflight    <= 1'b0;
            halted      <= 1'b0;
            addr        <= RESET_PC;
            inflight_pc <= RESET_PC;
            held_pc     <= '0;
            held_op     <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                q[i] <= '0;
            end
        end else if (bus.redirect_valid) begin
            state    <= ST_OPCODE;
            count    <= '0;
            valid    <= 1'b0;
            inflight <= 1'b0;
            halted   <= 1'b0;
            addr     <= bus.redirect_pc;
        end else begin
            inflight <= issue_c;
            if (issue_c) begin
                inflight_pc <= addr;
                addr        <= addr + 16'd1;
            end
            if (halt_c) begin
                halted <= 1'b1;
            end
            if (inflight) begin
                if (state == ST_OPCODE && two_word_c) begin
                    state   <= ST_OPERAND;
                    held_pc <= inflight_pc;
                    held_op <= bus.q_rom;
                end else begin
                    state <= ST_OPCODE;
                end
            end
            if (pop_c) begin
                for (int i = 0; i < int'(DEPTH) - 1; i++) begin
                    q[i] <= q[i+1];
                end
            end
            if (push_c) begin
                for (int i = 0; i < int'(DEPTH); i++) begin
                    if (CW'(i) == wr_idx_c) begin
                        q[i] <= entry_c;
                    end
                end
            end
            count <= count_nxt_c;
            valid <= (count_nxt_c != '0);
        end
    end

    assign bus.address_rom  = addr;
    assign bus.insn_valid   = valid;
    assign bus.insn_opcode  = q[0].opcode;
    assign bus.insn_operand = q[0].operand;
    assign bus.insn_pc      = q[0].pc;
endmodule
